// File: rtl/r5p_gpr_dbg.sv
// Debug-side GPR initiator: halts the core, drives the rs1/rd ports for a command, then releases the core.
// Optional burst support via `define R5P_GPR_DBG_BURST_EN (req_cnt ignored when undefined).
module r5p_gpr_dbg #(
  parameter int unsigned AW   = 5,
  parameter int unsigned XLEN = 32,
  parameter int unsigned CW   = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_vld,
  output logic            req_rdy,
  input  logic            req_wr,
  input  logic [AW-1:0]   req_adr,
  input  logic [CW-1:0]   req_cnt,
  input  logic            wdt_vld,
  output logic            wdt_rdy,
  input  logic [XLEN-1:0] wdt_dat,
  output logic            rsp_vld,
  input  logic            rsp_rdy,
  output logic [XLEN-1:0] rsp_dat,
  output logic            hlt_req,
  input  logic            hlt_ack,
  output logic            e_rs1,
  output logic [AW-1:0]   a_rs1,
  input  logic [XLEN-1:0] d_rs1,
  output logic            e_rd,
  output logic [AW-1:0]   a_rd,
  output logic [XLEN-1:0] d_rd
);

  typedef enum logic [1:0] {IDLE, HALT, XFER, DONE} state_t;

  state_t          state;
  state_t          state_nxt;
  logic            cmd_wr;
  logic [AW-1:0]   adr;
  logic            iss_done;
  logic            last_beat;
  logic            wr_beat;
  logic            rd_beat;
  logic            cmd_acc;
  logic            rsp_hsk;

  assign cmd_acc = (state == IDLE) & req_vld;
  assign rsp_hsk = rsp_vld & rsp_rdy;

`ifdef R5P_GPR_DBG_BURST_EN
  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cmd_acc) begin
      cnt <= req_cnt;
    end else if (wr_beat || rd_beat) begin
      cnt <= cnt - CW'(1);
    end
  end

  assign last_beat = (cnt == '0);
`else
  logic unused_cnt;

  assign unused_cnt = ^req_cnt;
  assign last_beat  = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    req_rdy   = 1'b0;
    wdt_rdy   = 1'b0;
    wr_beat   = 1'b0;
    rd_beat   = 1'b0;
    e_rd      = 1'b0;
    a_rd      = '0;
    d_rd      = '0;
    e_rs1     = 1'b0;
    a_rs1     = '0;
    case (state)
      IDLE: begin
        req_rdy = 1'b1;
        if (req_vld) state_nxt = HALT;
      end
      HALT: begin
        if (hlt_ack) state_nxt = XFER;
      end
      XFER: begin
        if (cmd_wr) begin
          wdt_rdy = 1'b1;
          if (wdt_vld) begin
            wr_beat = 1'b1;
            e_rd    = 1'b1;
            a_rd    = adr;
            d_rd    = wdt_dat;
            if (last_beat) state_nxt = DONE;
          end
        end else begin
          // the one-entry response buffer may be refilled in the cycle it drains
          if (!iss_done && (!rsp_vld || rsp_rdy)) begin
            rd_beat = 1'b1;
            e_rs1   = 1'b1;
            a_rs1   = adr;
          end
          if (iss_done && rsp_hsk) state_nxt = DONE;
        end
      end
      DONE: begin
        if (!hlt_ack) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hlt_req  <= 1'b0;
      cmd_wr   <= 1'b0;
      adr      <= '0;
      iss_done <= 1'b0;
      rsp_vld  <= 1'b0;
      rsp_dat  <= '0;
    end else begin
      if (cmd_acc) begin
        hlt_req  <= 1'b1;
        cmd_wr   <= req_wr;
        adr      <= req_adr;
        iss_done <= 1'b0;
      end
      if (state == XFER && state_nxt == DONE) hlt_req <= 1'b0;
      if (wr_beat || rd_beat) adr <= adr + AW'(1);
      if (rd_beat) begin
        rsp_dat  <= d_rs1;
        iss_done <= last_beat;
      end
      if (rd_beat) begin
        rsp_vld <= 1'b1;
      end else if (rsp_rdy) begin
        rsp_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_r5p_gpr_dbg.sv
// Randomized bench for r5p_gpr_dbg: core/GPR environment plus an array-based reference of register contents.
`timescale 1ns/1ps
module tb_r5p_gpr_dbg;
  localparam int AW = 5, XLEN = 32, CW = 5;
`ifdef R5P_GPR_DBG_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic            req_vld, req_rdy, req_wr;
  logic [AW-1:0]   req_adr;
  logic [CW-1:0]   req_cnt;
  logic            wdt_vld, wdt_rdy;
  logic [XLEN-1:0] wdt_dat;
  logic            rsp_vld, rsp_rdy;
  logic [XLEN-1:0] rsp_dat;
  logic            hlt_req, hlt_ack;
  logic            e_rs1, e_rd;
  logic [AW-1:0]   a_rs1, a_rd;
  logic [XLEN-1:0] d_rs1, d_rd;

  always #5 clk = ~clk;

  r5p_gpr_dbg #(.AW(AW), .XLEN(XLEN), .CW(CW)) dut (
    .clk(clk), .rst(rst),
    .req_vld(req_vld), .req_rdy(req_rdy), .req_wr(req_wr), .req_adr(req_adr), .req_cnt(req_cnt),
    .wdt_vld(wdt_vld), .wdt_rdy(wdt_rdy), .wdt_dat(wdt_dat),
    .rsp_vld(rsp_vld), .rsp_rdy(rsp_rdy), .rsp_dat(rsp_dat),
    .hlt_req(hlt_req), .hlt_ack(hlt_ack),
    .e_rs1(e_rs1), .a_rs1(a_rs1), .d_rs1(d_rs1),
    .e_rd(e_rd), .a_rd(a_rd), .d_rd(d_rd)
  );

  logic [XLEN-1:0] gpr [32];
  logic [XLEN-1:0] mdl [32];
  logic [XLEN-1:0] wdata [8];
  int errors = 0;
  int checks = 0;
  int ack_dly = 0;

  assign d_rs1 = gpr[a_rs1];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // register file: x0 is hardwired, writes land mid-cycle while inputs are stable
  initial forever begin
    @(negedge clk);
    if (rst && e_rd && a_rd != 0) gpr[a_rd] = d_rd;
  end

  // core: acknowledges a halt after ack_dly cycles, releases 0..2 cycles after hlt_req drops
  initial begin
    int acnt, dcnt, ddly;
    hlt_ack = 1'b0; acnt = 0; dcnt = 0; ddly = 0;
    forever begin
      @(posedge clk); #1;
      if (hlt_req && !hlt_ack) begin
        if (acnt >= ack_dly) begin
          hlt_ack = 1'b1; dcnt = 0; ddly = $urandom % 3;
        end else acnt++;
      end else if (!hlt_req && hlt_ack) begin
        if (dcnt >= ddly) begin
          hlt_ack = 1'b0; acnt = 0;
        end else dcnt++;
      end
    end
  end

  task automatic run_cmd(input bit wr, input int adr, input int cnt, input int rmode,
                         input bit vrand, input int ackd);
    int beats, idx, got, cyc, a;
    bit acked, ack_prev, fin, fin_ack0, done, exp_vld, exp_iss;
    beats = BURST ? cnt + 1 : 1;
    ack_dly = ackd;
    @(posedge clk); #1;
    chk("idle_rdy", req_rdy, 1);
    req_vld = 1'b1; req_wr = wr; req_adr = AW'(adr); req_cnt = CW'(cnt);
    idx = 0; got = 0; cyc = 0;
    acked = 0; ack_prev = 0; fin = 0; fin_ack0 = 0; done = 0;
    while (!done) begin
      @(posedge clk); #1;
      req_vld = 1'b0;
      rsp_rdy = (rmode == 0) ? 1'b1 : (rmode == 1) ? (cyc % 2 == 0) : 1'($urandom % 2);
      wdt_vld = wr && idx < beats && (!vrand || ($urandom % 2 == 1));
      wdt_dat = wdata[idx % 8];
      #1;
      acked |= ack_prev;
      if (fin) begin
        chk("done_rdy", req_rdy, fin_ack0);
        if (fin_ack0) done = 1;
        if (!hlt_ack) fin_ack0 = 1;
      end else chk("busy_rdy", req_rdy, 0);
      if (wr) begin
        chk("wr_hlt_req", hlt_req, idx < beats);
        chk("wdt_rdy", wdt_rdy, acked && idx < beats);
        chk("wr_e_rs1", e_rs1, 0);
        if (acked && idx < beats && wdt_vld) begin
          a = (adr + idx) % 32;
          chk("e_rd", e_rd, 1);
          chk("a_rd", a_rd, a);
          chk("d_rd", d_rd, wdt_dat);
          if (a != 0) mdl[a] = wdt_dat;
          idx++;
          if (idx == beats) fin = 1;
        end else begin
          chk("e_rd_idle", e_rd, 0);
          chk("a_rd_idle", a_rd, 0);
          chk("d_rd_idle", d_rd, 0);
        end
      end else begin
        exp_vld = idx > got;
        chk("rd_hlt_req", hlt_req, got < beats);
        chk("rsp_vld", rsp_vld, exp_vld);
        if (exp_vld) chk("rsp_dat", rsp_dat, mdl[(adr + got) % 32]);
        exp_iss = acked && idx < beats && (!exp_vld || rsp_rdy);
        chk("e_rs1", e_rs1, exp_iss);
        chk("a_rs1", a_rs1, exp_iss ? (adr + idx) % 32 : 0);
        chk("rd_e_rd", e_rd, 0);
        if (exp_vld && rsp_rdy) got++;
        if (exp_iss) idx++;
        if (got == beats) fin = 1;
      end
      ack_prev = hlt_ack;
      cyc++;
      if (cyc > 400) begin
        chk("timeout", 0, 1);
        done = 1;
      end
    end
    rsp_rdy = 1'b0; wdt_vld = 1'b0;
  endtask

  task automatic mid_reset(input bit wr);
    int n;
    ack_dly = 0;
    @(posedge clk); #1;
    req_vld = 1'b1; req_wr = wr; req_adr = 12; req_cnt = 5; rsp_rdy = 1'b0;
    @(posedge clk); #1;
    req_vld = 1'b0;
    n = 0;
    while (!(wr ? wdt_rdy : rsp_vld) && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("mid_xfer_reached", n < 20, 1);
    if (wr) begin
      wdt_vld = 1'b1; wdt_dat = 32'hCAFE0000;
      #1 chk("mid_e_rd_pre", e_rd, 1);
    end else begin
      #1 chk("mid_vld_pre", rsp_vld, 1);
    end
    #1 rst = 1'b0;
    #1;
    chk("mid_hlt_req", hlt_req, 0);
    chk("mid_rsp_vld", rsp_vld, 0);
    chk("mid_e_rd", e_rd, 0);
    chk("mid_e_rs1", e_rs1, 0);
    chk("mid_req_rdy", req_rdy, 1);
    chk("mid_wdt_rdy", wdt_rdy, 0);
    chk("mid_rsp_dat", rsp_dat, 0);
    wdt_vld = 1'b0;
    #2 rst = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("post_rst_rdy", req_rdy, 1);
    chk("post_rst_hlt", hlt_req, 0);
  endtask

  initial begin
    rst = 1'b0;
    req_vld = 0; req_wr = 0; req_adr = '0; req_cnt = '0;
    wdt_vld = 0; wdt_dat = '0; rsp_rdy = 0;
    for (int i = 0; i < 32; i++) begin
      gpr[i] = (i == 0) ? '0 : $urandom;
    end
    gpr[5] = 32'hDEADBEEF;
    for (int i = 0; i < 32; i++) mdl[i] = gpr[i];
    #12;
    chk("rst_req_rdy", req_rdy, 1);
    chk("rst_hlt_req", hlt_req, 0);
    chk("rst_wdt_rdy", wdt_rdy, 0);
    chk("rst_rsp_vld", rsp_vld, 0);
    chk("rst_rsp_dat", rsp_dat, 0);
    chk("rst_e_rs1", e_rs1, 0);
    chk("rst_e_rd", e_rd, 0);
    chk("rst_a_rs1", a_rs1, 0);
    chk("rst_a_rd", a_rd, 0);
    chk("rst_d_rd", d_rd, 0);
    #1 rst = 1'b1;

    run_cmd(1'b0, 5, 0, 0, 1'b0, 3);
    wdata[0] = 32'h11; wdata[1] = 32'h22; wdata[2] = 32'h33; wdata[3] = 32'h44;
    run_cmd(1'b1, 30, 3, 0, 1'b0, 1);
    run_cmd(1'b0, 30, 3, 0, 1'b0, 0);
    chk("x0_model", gpr[0], 0);
    run_cmd(1'b0, 20, 7, 1, 1'b0, 2);
    mid_reset(1'b1);
    mid_reset(1'b0);
    for (int k = 0; k < 24; k++) begin
      for (int j = 0; j < 8; j++) wdata[j] = $urandom;
      run_cmd(1'($urandom % 2), $urandom % 32, $urandom % 8, $urandom % 3,
              1'($urandom % 2), $urandom % 4);
    end
    for (int i = 0; i < 32; i++) chk("gpr_final", gpr[i], mdl[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

endmodule
